// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

   localparam int DEFAULT_OSR = 16;
   localparam int CFG_BITS_W  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } rx_state_e;

   typedef struct packed {
      logic [CFG_BITS_W-1:0] data_bits;
      logic                  parity_en;
      logic                  parity_odd;
      logic                  two_stop;
   } rx_cfg_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Data-bit count is forced into 5..max_bits so a bad setting still frames sanely.
   function automatic logic [CFG_BITS_W-1:0] clamp_bits(input logic [CFG_BITS_W-1:0] raw,
                                                       input logic [CFG_BITS_W-1:0] max_bits);
      logic [CFG_BITS_W-1:0] res;
      if (raw < 4'd5) begin
         res = 4'd5;
      end else if (raw > max_bits) begin
         res = max_bits;
      end else begin
         res = raw;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Consumer-side handshake bundle of the receiver: one held frame plus its flags.
interface uart_rx_cfg_if #(
   parameter int DATA_SIZE = 8
) ();
   logic                 rx_valid;
   logic                 rx_ready;
   logic [DATA_SIZE-1:0] data_out;
   logic                 parity_error;
   logic                 stop_error;
   logic                 break_error;
   logic                 rx_done;
   logic                 overflow_error;

   modport master (
      output rx_valid, data_out, parity_error, stop_error, break_error,
             rx_done, overflow_error,
      input  rx_ready
   );

   modport slave (
      input  rx_valid, data_out, parity_error, stop_error, break_error,
             rx_done, overflow_error,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line front end: synchronizer, falling-edge detect, per-bit tick counter and
// three-sample majority vote around mid-bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OSR         = DEFAULT_OSR,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_tick,
   input  logic serial_data_in,
   input  logic active,
   output logic start_edge,
   output logic bit_valid,
   output logic bit_value,
   output logic bit_end
);

   localparam int CNT_W = $clog2(OSR);
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OSR/2 - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OSR/2);
   localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(OSR/2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   samp0_q, samp0_d;
   logic                   samp1_q, samp1_d;
   logic                   line_s;

   assign line_s = sync_q[SYNC_STAGES-1];

   // Next-state for synchronizer, previous-sample, tick counter and vote samples.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], serial_data_in};
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      samp0_d = samp0_q;
      samp1_d = samp1_q;
      if (sample_tick) begin
         prev_d = line_s;
         if (!active) begin
            cnt_d = {CNT_W{1'b0}};
         end else if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (cnt_q == CNT_S0) begin
            samp0_d = line_s;
         end else begin
            samp0_d = samp0_q;
         end
         if (cnt_q == CNT_S1) begin
            samp1_d = line_s;
         end else begin
            samp1_d = samp1_q;
         end
      end else begin
         prev_d = prev_q;
      end
   end

   // Sampler state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{1'b1}};
         prev_q  <= 1'b1;
         cnt_q   <= {CNT_W{1'b0}};
         samp0_q <= 1'b0;
         samp1_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         samp0_q <= samp0_d;
         samp1_q <= samp1_d;
      end
   end

   // The third sample is the live line, so the vote resolves in the same tick.
   assign start_edge = sample_tick & prev_q & ~line_s;
   assign bit_valid  = sample_tick & active & (cnt_q == CNT_VOTE);
   assign bit_end    = sample_tick & active & (cnt_q == CNT_LAST);
   assign bit_value  = majority3(samp0_q, samp1_q, line_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime frame format and a one-entry
// holding register read through a valid/ready handshake.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_SIZE   = 8,
   parameter int OSR         = DEFAULT_OSR,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sample_tick,
   input  logic                           serial_data_in,
   input  logic                           rx_enable,
   input  logic [$clog2(DATA_SIZE+1)-1:0] cfg_data_bits,
   input  logic                           cfg_parity_en,
   input  logic                           cfg_parity_odd,
   input  logic                           cfg_two_stop,
   uart_rx_cfg_if.master                  rx_if
);

   localparam logic [CFG_BITS_W-1:0] MAX_BITS = CFG_BITS_W'(DATA_SIZE);
   localparam logic [CFG_BITS_W-1:0] IDX_ONE  = CFG_BITS_W'(1);

   rx_state_e             state_q, state_d;
   rx_cfg_t               cfg_q, cfg_d;
   logic [DATA_SIZE-1:0]  shift_q, shift_d;
   logic [CFG_BITS_W-1:0] bit_idx_q, bit_idx_d;
   logic                  par_bit_q, par_bit_d;
   logic                  stop_err_q, stop_err_d;
   logic                  stop_zero_q, stop_zero_d;

   logic                  valid_q, valid_d;
   logic [DATA_SIZE-1:0]  data_q, data_d;
   logic                  perr_q, perr_d;
   logic                  serr_q, serr_d;
   logic                  berr_q, berr_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;

   logic start_edge_s, bit_valid_s, bit_value_s, bit_end_s;
   logic complete_s, fin_serr_s, fin_szero_s, perr_s, berr_s;

   uart_rx_sampler #(
      .OSR         (OSR),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk            (clk),
      .reset          (reset),
      .sample_tick    (sample_tick),
      .serial_data_in (serial_data_in),
      .active         (state_q != IDLE),
      .start_edge     (start_edge_s),
      .bit_valid      (bit_valid_s),
      .bit_value      (bit_value_s),
      .bit_end        (bit_end_s)
   );

   // Flags as they stand once the current (last) stop bit is folded in.
   assign fin_serr_s  = stop_err_q | ~bit_value_s;
   assign fin_szero_s = stop_zero_q & ~bit_value_s;
   assign perr_s      = cfg_q.parity_en & ((^shift_q) ^ par_bit_q ^ cfg_q.parity_odd);
   assign berr_s      = (shift_q == {DATA_SIZE{1'b0}}) & ~(cfg_q.parity_en & par_bit_q) & fin_szero_s;

   // Frame FSM next-state plus holding-register update.
   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      par_bit_d   = par_bit_q;
      stop_err_d  = stop_err_q;
      stop_zero_d = stop_zero_q;
      complete_s  = 1'b0;
      valid_d     = valid_q;
      data_d      = data_q;
      perr_d      = perr_q;
      serr_d      = serr_q;
      berr_d      = berr_q;
      done_d      = 1'b0;
      ovf_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_edge_s && rx_enable) begin
               state_d          = START;
               cfg_d.data_bits  = clamp_bits(CFG_BITS_W'(cfg_data_bits), MAX_BITS);
               cfg_d.parity_en  = cfg_parity_en;
               cfg_d.parity_odd = cfg_parity_odd;
               cfg_d.two_stop   = cfg_two_stop;
               shift_d          = {DATA_SIZE{1'b0}};
               bit_idx_d        = {CFG_BITS_W{1'b0}};
               par_bit_d        = 1'b0;
               stop_err_d       = 1'b0;
               stop_zero_d      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_valid_s && bit_value_s) begin
               state_d = IDLE;
            end else if (bit_end_s) begin
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_valid_s) begin
               for (int i = 0; i < DATA_SIZE; i++) begin
                  if (CFG_BITS_W'(i) == bit_idx_q) begin
                     shift_d[i] = bit_value_s;
                  end else begin
                     shift_d[i] = shift_q[i];
                  end
               end
               bit_idx_d = bit_idx_q + IDX_ONE;
            end else if (bit_end_s && (bit_idx_q == cfg_q.data_bits)) begin
               state_d = cfg_q.parity_en ? PARITY : STOP1;
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_valid_s) begin
               par_bit_d = bit_value_s;
            end else if (bit_end_s) begin
               state_d = STOP1;
            end else begin
               state_d = PARITY;
            end
         end
         STOP1: begin
            if (bit_valid_s) begin
               stop_err_d  = fin_serr_s;
               stop_zero_d = fin_szero_s;
               if (!cfg_q.two_stop) begin
                  complete_s = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = STOP1;
               end
            end else if (bit_end_s) begin
               state_d = STOP2;
            end else begin
               state_d = STOP1;
            end
         end
         STOP2: begin
            if (bit_valid_s) begin
               complete_s = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = STOP2;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Disabling the receiver drops a frame in flight without reporting it.
      if ((state_q != IDLE) && !rx_enable) begin
         state_d    = IDLE;
         complete_s = 1'b0;
      end else begin
         state_d = state_d;
      end

      done_d = complete_s;
      if (complete_s) begin
         if (!valid_q || rx_if.rx_ready) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_s;
            serr_d  = fin_serr_s;
            berr_d  = berr_s;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && rx_if.rx_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame datapath and holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q       <= {$bits(rx_cfg_t){1'b0}};
         shift_q     <= {DATA_SIZE{1'b0}};
         bit_idx_q   <= {CFG_BITS_W{1'b0}};
         par_bit_q   <= 1'b0;
         stop_err_q  <= 1'b0;
         stop_zero_q <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= {DATA_SIZE{1'b0}};
         perr_q      <= 1'b0;
         serr_q      <= 1'b0;
         berr_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         cfg_q       <= cfg_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         par_bit_q   <= par_bit_d;
         stop_err_q  <= stop_err_d;
         stop_zero_q <= stop_zero_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         perr_q      <= perr_d;
         serr_q      <= serr_d;
         berr_q      <= berr_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   assign rx_if.rx_valid       = valid_q;
   assign rx_if.data_out       = data_q;
   assign rx_if.parity_error   = perr_q;
   assign rx_if.stop_error     = serr_q;
   assign rx_if.break_error    = berr_q;
   assign rx_if.rx_done        = done_q;
   assign rx_if.overflow_error = ovf_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a frame-format vector table plus hand-written
// sequences for false start, break, overflow and abort.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int DS  = 8;
   localparam int OSR = 16;
   localparam int SYN = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_tick;
   logic       serial;
   logic       rx_enable;
   logic [3:0] cfg_bits;
   logic       cfg_pen, cfg_podd, cfg_two;

   uart_rx_cfg_if #(.DATA_SIZE(DS)) rx_if ();

   uart_rx_cfg #(.DATA_SIZE(DS), .OSR(OSR), .SYNC_STAGES(SYN)) dut (
      .clk            (clk),
      .reset          (reset),
      .sample_tick    (sample_tick),
      .serial_data_in (serial),
      .rx_enable      (rx_enable),
      .cfg_data_bits  (cfg_bits),
      .cfg_parity_en  (cfg_pen),
      .cfg_parity_odd (cfg_podd),
      .cfg_two_stop   (cfg_two),
      .rx_if          (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int ovf_cnt = 0;
   int t_start = 0;
   int cap_cyc = 0;
   logic [7:0] cap_data;
   logic cap_perr, cap_serr, cap_berr, cap_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture the outputs at every completion pulse.
   always @(negedge clk) begin
      if (rx_if.overflow_error) ovf_cnt <= ovf_cnt + 1;
      if (rx_if.rx_done) begin
         done_cnt <= done_cnt + 1;
         cap_cyc  <= cyc;
         cap_data <= rx_if.data_out;
         cap_perr <= rx_if.parity_error;
         cap_serr <= rx_if.stop_error;
         cap_berr <= rx_if.break_error;
         cap_ovf  <= rx_if.overflow_error;
      end
   end

   typedef struct {
      logic [3:0] cfg_n;
      int         sbits;
      logic       pen, podd, two;
      logic [7:0] data;
      logic       par_bit, stop2, glitch;
      logic [7:0] exp_data;
      logic       exp_perr, exp_serr, exp_berr;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_level(input logic val, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         serial = val;
      end
   endtask

   task automatic send_frame(input int sbits, input logic pen, input logic par_bit,
                             input logic two, input logic [7:0] data, input logic stop1,
                             input logic stop2, input logic glitch);
      logic bl [0:11];
      int nb;
      bl[0] = 1'b0;
      nb = 1;
      for (int i = 0; i < sbits; i++) begin
         bl[nb] = data[i];
         nb = nb + 1;
      end
      if (pen) begin
         bl[nb] = par_bit;
         nb = nb + 1;
      end
      bl[nb] = stop1;
      nb = nb + 1;
      if (two) begin
         bl[nb] = stop2;
         nb = nb + 1;
      end
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < OSR; c++) begin
            @(negedge clk);
            if (b == 0 && c == 0) t_start = cyc;
            // A one-cycle glitch on the middle sample of data bit 0 must be voted out.
            serial = bl[b] ^ (glitch && b == 1 && c == 9);
         end
      end
      drive_level(1'b1, 2*OSR);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
   endtask

   task automatic consume();
      @(negedge clk);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
   endtask

   task automatic set_cfg(input logic [3:0] n, input logic pen, input logic podd, input logic two);
      cfg_bits = n;
      cfg_pen  = pen;
      cfg_podd = podd;
      cfg_two  = two;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int d0;
      int o0;
      int lat;
      vecs[0] = '{4'd8,  8, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd8,  8, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'd8,  8, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'd5,  5, 1'b1, 1'b1, 1'b1, 8'h1B, 1'b1, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{4'd7,  7, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{4'd6,  6, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{4'd3,  5, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{4'd15, 8, 1'b0, 1'b0, 1'b0, 8'hC7, 1'b0, 1'b1, 1'b0, 8'hC7, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{4'd8,  8, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      sample_tick = 1'b1;
      serial = 1'b1;
      rx_enable = 1'b1;
      rx_if.rx_ready = 1'b0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_valid", rx_if.rx_valid, 0);
      chk("reset_data", rx_if.data_out, 0);
      chk("reset_flags", {rx_if.parity_error, rx_if.stop_error, rx_if.break_error}, 0);
      chk("reset_pulses", {rx_if.rx_done, rx_if.overflow_error}, 0);
      chk("reset_state", dut.state_q, IDLE);

      // False start: a 3-tick low glitch never survives the start-bit vote.
      drive_level(1'b0, 3);
      drive_level(1'b1, 4*OSR);
      chk("false_start_done", done_cnt, 0);
      chk("false_start_valid", rx_if.rx_valid, 0);
      chk("false_start_state", dut.state_q, IDLE);

      for (int v = 0; v < 9; v++) begin
         set_cfg(vecs[v].cfg_n, vecs[v].pen, vecs[v].podd, vecs[v].two);
         d0 = done_cnt;
         o0 = ovf_cnt;
         send_frame(vecs[v].sbits, vecs[v].pen, vecs[v].par_bit, vecs[v].two,
                    vecs[v].data, 1'b1, vecs[v].stop2, vecs[v].glitch);
         wait_done(d0 + 1);
         chk($sformatf("v%0d_done", v), done_cnt, d0 + 1);
         chk($sformatf("v%0d_data", v), cap_data, vecs[v].exp_data);
         chk($sformatf("v%0d_perr", v), cap_perr, vecs[v].exp_perr);
         chk($sformatf("v%0d_serr", v), cap_serr, vecs[v].exp_serr);
         chk($sformatf("v%0d_berr", v), cap_berr, vecs[v].exp_berr);
         chk($sformatf("v%0d_ovf", v), ovf_cnt, o0);
         chk($sformatf("v%0d_valid", v), rx_if.rx_valid, 1);
         if (v == 0) begin
            // 8N1 at OSR 16: 9.5 bit times = 152 ticks, plus sync and edge/register stages.
            lat = cap_cyc - t_start;
            chk("latency_8n1", (lat >= 152 + SYN && lat <= 152 + SYN + 4) ? 1 : 0, 1);
         end
         consume();
         chk($sformatf("v%0d_read_valid", v), rx_if.rx_valid, 0);
         chk($sformatf("v%0d_read_hold", v), rx_if.data_out, vecs[v].exp_data);
      end

      // Break: line low for 12 bit times; one frame only, no restart while low.
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      d0 = done_cnt;
      drive_level(1'b0, 12*OSR);
      chk("break_done", done_cnt, d0 + 1);
      chk("break_data", cap_data, 0);
      chk("break_flags", {cap_perr, cap_serr, cap_berr}, 3'b011);
      drive_level(1'b1, 3*OSR);
      chk("break_no_second", done_cnt, d0 + 1);
      consume();

      // Overflow: second frame dropped while the first is unread.
      d0 = done_cnt;
      o0 = ovf_cnt;
      send_frame(8, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0);
      send_frame(8, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0);
      wait_done(d0 + 2);
      chk("ovf_done", done_cnt, d0 + 2);
      chk("ovf_pulse_at_done", cap_ovf, 1);
      chk("ovf_count", ovf_cnt, o0 + 1);
      chk("ovf_data_kept", rx_if.data_out, 8'h11);
      chk("ovf_valid", rx_if.rx_valid, 1);
      @(negedge clk);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
      chk("ovf_read_valid", rx_if.rx_valid, 0);
      chk("ovf_read_hold", rx_if.data_out, 8'h11);

      // Abort mid-DATA via rx_enable.
      d0 = done_cnt;
      drive_level(1'b0, OSR);
      drive_level(1'b1, OSR);
      drive_level(1'b0, OSR);
      drive_level(1'b1, OSR);
      chk("abort_in_data", dut.state_q, DATA);
      @(negedge clk);
      rx_enable = 1'b0;
      serial = 1'b1;
      @(negedge clk);
      chk("abort_state", dut.state_q, IDLE);
      rx_enable = 1'b1;
      drive_level(1'b1, 12*OSR);
      chk("abort_no_done", done_cnt, d0);
      chk("abort_valid", rx_if.rx_valid, 0);

      // Recovery frame after the abort.
      send_frame(8, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 1'b1, 1'b0);
      wait_done(d0 + 1);
      chk("recover_done", done_cnt, d0 + 1);
      chk("recover_data", rx_if.data_out, 8'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed-format UART receiver. It oversamples the serial line with majority voting and supports a runtime-selectable frame format: 5..DATA_SIZE data bits, none/even/odd parity, and 1 or 2 stop bits. Received frames and their error flags go into a one-entry holding register that is read with a valid/ready handshake. It sits between the pin-side baud-tick generator and the bus-side RX FIFO/register interface.

Parameters:
DATA_SIZE, 8, maximum data bits per frame (5..9)
OSR, 16, oversampling ratio (sample ticks per bit); even, >= 8
SYNC_STAGES, 2, input synchronizer depth (>= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_tick  input  1  one-cycle strobe at OSR x baud; all line sampling and counting advances only on it
serial_data_in  input  1  asynchronous RX line, idle high
rx_enable  input  1  receiver enable; low = idle, or abort a frame in progress
cfg_data_bits  input  $clog2(DATA_SIZE+1)  data bits per frame, 5..DATA_SIZE; out-of-range values are clamped into that range
cfg_parity_en  input  1  parity bit present
cfg_parity_odd  input  1  1 = odd parity, 0 = even
cfg_two_stop  input  1  2 stop bits
rx_valid  output  1  holding register holds an unread frame
rx_ready  input  1  consumer accepts the frame when rx_valid & rx_ready
data_out  output  DATA_SIZE  received data, LSB-first, right-justified, unused upper bits 0
parity_error  output  1  parity mismatch (qualified by rx_valid)
stop_error  output  1  a stop bit was sampled 0 (qualified by rx_valid)
break_error  output  1  data, parity and stop bits all 0 (qualified by rx_valid)
rx_done  output  1  one-cycle pulse when a frame completes (stored or dropped)
overflow_error  output  1  one-cycle pulse; a frame completed while rx_valid & !rx_ready, and the new frame was dropped

Behaviour:
- Reset: FSM to IDLE, synchronizer flops to 1, all counters to 0, every output to 0 (data_out 0).
- The synchronizer runs every clk. The FSM, tick counter and samples advance only when sample_tick is high.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on sample_tick, synced line = 0 with previous sample = 1 and rx_enable high -> START, tick_cnt = 0. Config inputs are latched at this point and held for the whole frame.
- Bit timing: tick_cnt counts 0..OSR-1 per bit.
  - The line is sampled at tick_cnt = OSR/2-1, OSR/2 and OSR/2+1.
  - The bit value is the majority of the three samples and is resolved at OSR/2+1.
- START: if the voted value is 1, it is a false start -> IDLE, with no rx_done. Otherwise continue at the bit boundary -> DATA.
- DATA: shift in cfg_data_bits bits, LSB first. After the last bit go to PARITY if parity is enabled, else STOP1.
- PARITY: parity_error = XOR(data bits, parity bit, cfg_parity_odd) != 0.
- STOP1 / STOP2: stop_error is set if any stop bit votes 0. STOP2 is entered only when cfg_two_stop is set.
- Frame completion is evaluated at the vote point of the last stop bit (mid-bit, not end of bit). The FSM returns to IDLE in that same tick.
- A new start is detected only after the line has been seen high.
- break_error = all data bits 0 & parity bit 0 (if enabled) & every stop bit 0.
- At completion:
  - rx_done pulses for one clk.
  - If rx_valid is 0, or rx_ready is 1 in the same cycle (simultaneous read), the frame and its flags load the holding register and rx_valid goes to 1.
  - Otherwise overflow_error pulses and the holding register is unchanged.
- rx_valid & rx_ready with no completion in that cycle: rx_valid goes to 0; data and flags hold their values.
- rx_enable low in any non-IDLE state: the frame is aborted next clk, the FSM goes to IDLE, and there is no rx_done. The holding register is unaffected.
- Latency, start edge to rx_done: about SYNC_STAGES clk + (1 + N + P + S - 0.5) * OSR ticks, where N = data bits, P = 1 if parity enabled else 0, S = number of stop bits.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP1, STOP2}
  - typedef struct rx_cfg_t {data_bits, parity_en, parity_odd, two_stop}
  - constant DEFAULT_OSR = 16
- One sub-module, uart_rx_sampler: synchronizer, falling-edge detect, tick counter and 3-sample majority vote. Outputs: bit_valid strobe, bit_value, start_edge.

Test Plan:
1. OSR=16, sample_tick always 1, 8N1, byte 0x55 -> one rx_done, rx_valid=1, data_out=0x55, all error flags 0. rx_done occurs 152 ticks (+sync) after the start edge.
2. 8E1, byte 0xA3 sent with parity bit 1 -> data_out=0xA3, parity_error=1. Resend with parity bit 0 -> parity_error=0.
3. Line low for 3 ticks, then high -> FSM returns to IDLE, no rx_done, rx_valid stays 0.
4. 8N1, line held low for 12 bit times -> data_out=0x00, break_error=1, stop_error=1. No second frame until the line returns high.
5. rx_ready=0; send 0x11 then 0x22 -> second rx_done pulses with overflow_error=1, data_out remains 0x11. Then rx_ready=1 -> rx_valid goes to 0 next cycle.
6. 5O2, data 0x1B with second stop bit 0 -> data_out=0x1B, stop_error=1. A separate frame with rx_enable dropped mid-DATA -> no rx_done, FSM in IDLE.
